frame_buffer_pp: RTL and testbench

//  Parametrised double-buffered (ping-pong) frame store; successor to the single-bank VGA image buffer.

---
 rtl/fb_pkg.sv | 35 +++
 rtl/frame_buffer_ram.sv | 34 +++
 rtl/frame_buffer_pp.sv | 162 ++++++++++++++++
 tb/tb_frame_buffer_pp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the ping-pong frame buffer.
// Offset/depth math lives here so top and RAM agree on address layout.
package fb_pkg;

    localparam int FB_BG_DEFAULT = 0;

    // Source of the display pixel held on rd_data.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BG,
        SRC_RAM
    } rd_src_e;

    function automatic int fb_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bits needed for y*W+x within one bank (at least one).
    function automatic int fb_off_w(input int w, input int h);
        int r;
        r = fb_clog2(w * h);
        return (r < 1) ? 1 : r;
    endfunction

    // Bank select is the MSB above the offset, so each bank spans a
    // full power-of-two window; this equals 2*W*H when W*H is a power
    // of two and keeps bank 1 addressable otherwise.
    function automatic int fb_ram_depth(input int w, input int h);
        return 1 << (fb_off_w(w, h) + 1);
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds when re_i is low; contents are never reset.
module frame_buffer_ram
    import fb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = fb_clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_pp.sv
// Double-buffered frame store: capture fills the back bank while
// display reads the front bank; banks swap only at frame start.
module frame_buffer_pp
    import fb_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter logic [PIX_W-1:0] BG_VALUE = PIX_W'(FB_BG_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_drop,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    input  logic             rd_mirror,
    input  logic             rd_frame_start,
    output logic             rd_valid,
    output logic [PIX_W-1:0] rd_data,
    output logic             front_bank,
    output logic             frame_pending,
    output logic [15:0]      drop_count
);

    localparam int OFF_W  = fb_off_w(IMG_WIDTH, IMG_HEIGHT);
    localparam int ADDR_W = OFF_W + 1;
    localparam int DEPTH  = fb_ram_depth(IMG_WIDTH, IMG_HEIGHT);

    localparam logic [X_W-1:0] W_X    = X_W'(IMG_WIDTH);
    localparam logic [Y_W-1:0] H_Y    = Y_W'(IMG_HEIGHT);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    function automatic logic [OFF_W-1:0] pix_off(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return OFF_W'(y) * OFF_W'(IMG_WIDTH) + OFF_W'(x);
    endfunction

    logic              front_q, front_d;
    logic              pending_q, pending_d;
    logic              wr_drop_q;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              wr_accept, wr_last;
    logic [ADDR_W-1:0] waddr;

    logic              rd_in_range;
    logic [X_W-1:0]    rd_col;
    logic              s1_valid_q, s1_in_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              rd_valid_q;
    rd_src_e           src_q;
    logic              ram_re;
    logic [PIX_W-1:0]  ram_rdata;

    assign wr_accept = wr_valid && (wr_x < W_X) && (wr_y < H_Y)
                       && !pending_q;
    assign wr_last   = (wr_x == X_LAST) && (wr_y == Y_LAST);
    assign waddr     = {~front_q, pix_off(wr_x, wr_y)};

    // Swap has priority; it needs pending already set, so a last-pixel
    // write in the same cycle only arms the next frame start.
    always_comb begin
        front_d    = front_q;
        pending_d  = pending_q;
        drop_cnt_d = drop_cnt_q;
        if (rd_frame_start && pending_q) begin
            front_d   = ~front_q;
            pending_d = 1'b0;
        end else if (wr_accept && wr_last) begin
            pending_d = 1'b1;
        end
        if (wr_valid && !wr_accept && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Bank/pending control, drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_q    <= 1'b0;
            pending_q  <= 1'b0;
            wr_drop_q  <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            front_q    <= front_d;
            pending_q  <= pending_d;
            wr_drop_q  <= wr_valid && !wr_accept;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rd_in_range = (rd_x < W_X) && (rd_y < H_Y);
    assign rd_col      = rd_mirror ? (X_LAST - rd_x) : rd_x;

    // Stage 1: range check, mirror and address; bank sampled here so a
    // later swap cannot redirect an in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_in_q    <= 1'b0;
            s1_addr_q  <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_in_q   <= rd_in_range;
                s1_addr_q <= {front_q, pix_off(rd_col, rd_y)};
            end
        end
    end

    assign ram_re = s1_valid_q && s1_in_q;

    // Stage 2: qualifier and data source; source holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            src_q      <= SRC_ZERO;
        end else begin
            rd_valid_q <= s1_valid_q;
            if (s1_valid_q) src_q <= s1_in_q ? SRC_RAM : SRC_BG;
        end
    end

    // Select the pixel presented on rd_data.
    always_comb begin
        rd_data = '0;
        case (src_q)
            SRC_RAM: rd_data = ram_rdata;
            SRC_BG:  rd_data = BG_VALUE;
            default: rd_data = '0;
        endcase
    end

    frame_buffer_ram #(
        .DATA_W(PIX_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (wr_accept),
        .waddr_i(waddr),
        .wdata_i(wr_data),
        .re_i   (ram_re),
        .raddr_i(s1_addr_q),
        .rdata_o(ram_rdata)
    );

    assign wr_drop       = wr_drop_q;
    assign rd_valid      = rd_valid_q;
    assign front_bank    = front_q;
    assign frame_pending = pending_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Scoreboard bench for frame_buffer_pp on a reduced 16x8 image.
// Reads push expected pixels; a negedge monitor pops and compares.
module tb_frame_buffer_pp;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int PW = 8;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam logic [PW-1:0] BG = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [PW-1:0] wr_data;
    logic          wr_drop;
    logic          rd_en;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_mirror;
    logic          rd_frame_start;
    logic          rd_valid;
    logic [PW-1:0] rd_data;
    logic          front_bank;
    logic          frame_pending;
    logic [15:0]   drop_count;

    frame_buffer_pp #(
        .PIX_W     (PW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .X_W       (XW),
        .Y_W       (YW),
        .BG_VALUE  (BG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_data       (wr_data),
        .wr_drop       (wr_drop),
        .rd_en         (rd_en),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_mirror     (rd_mirror),
        .rd_frame_start(rd_frame_start),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .front_bank    (front_bank),
        .frame_pending (frame_pending),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            cyc;
        logic [PW-1:0] data;
        bit            dc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every presented pixel must match the oldest request.
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected actual=valid required=idle");
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc + 2) begin
                    failures++;
                    $display("FAIL rd_latency actual=%0d required=%0d",
                             cyc - mon_e.cyc, 2);
                end
                if (!mon_e.dc) begin
                    checks++;
                    if (rd_data !== mon_e.data) begin
                        failures++;
                        $display("FAIL rd_data actual=%0h required=%0h",
                                 rd_data, mon_e.data);
                    end
                end
            end
        end
    end

    function automatic logic [PW-1:0] pix(input int k, input int x,
                                          input int y);
        case (k)
            1:       return 8'((x + y) & 255);
            2:       return 8'((2 * x + y + 1) & 255);
            3:       return 8'(((y << 4) | x) & 255);
            default: return 8'((3 * x + 5 * y + 7) & 255);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_issue(input int x, input int y, input bit m,
                            input logic [PW-1:0] d, input bit dc);
        rd_en     = 1'b1;
        rd_x      = XW'(x);
        rd_y      = YW'(y);
        rd_mirror = m;
        q.push_back('{cyc, d, dc});
        tick();
    endtask

    task automatic rd_stop();
        rd_en     = 1'b0;
        rd_mirror = 1'b0;
    endtask

    task automatic wr_px(input int x, input int y, input logic [PW-1:0] d);
        wr_valid = 1'b1;
        wr_x     = XW'(x);
        wr_y     = YW'(y);
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wr_frame(input int k, input bit skip_last);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (!(skip_last && x == W - 1 && y == H - 1))
                    wr_px(x, y, pix(k, x, y));
    endtask

    task automatic fstart();
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        rd_en = 1'b0; rd_x = '0; rd_y = '0; rd_mirror = 1'b0;
        rd_frame_start = 1'b0;
        repeat (3) tick();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_wr_drop", 32'(wr_drop), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_front", 32'(front_bank), 0);
        chk("rst_pending", 32'(frame_pending), 0);
        rst = 1'b1;
        tick();

        // Read from bank 0 before any frame: only latency is checked.
        rd_issue(5, 5, 0, 8'h00, 1);
        rd_stop();
        drain();
        chk("rd_idle", 32'(rd_valid), 0);
        chk("f0_front", 32'(front_bank), 0);
        chk("f0_pending", 32'(frame_pending), 0);

        // Frame 1 into bank 1, then swap.
        wr_frame(1, 0);
        chk("f1_pending", 32'(frame_pending), 1);
        chk("f1_front_held", 32'(front_bank), 0);
        fstart();
        chk("f1_swap_front", 32'(front_bank), 1);
        chk("f1_swap_pending", 32'(frame_pending), 0);

        // Back-to-back reads including mirror and out-of-area.
        rd_issue(10, 3, 0, 8'd13, 0);
        rd_issue(0, 3, 1, 8'd18, 0);
        rd_issue(16, 0, 0, BG, 0);
        rd_issue(0, 8, 0, BG, 0);
        rd_issue(15, 7, 0, 8'd22, 0);
        rd_issue(3, 0, 1, 8'd12, 0);
        rd_stop();
        drain();

        // Frame 2 into bank 0; a write while pending must drop.
        wr_frame(2, 0);
        chk("f2_pending", 32'(frame_pending), 1);
        wr_px(0, 0, 8'hEE);
        chk("drop_pulse", 32'(wr_drop), 1);
        chk("drop_count_1", 32'(drop_count), 1);
        tick();
        chk("drop_pulse_end", 32'(wr_drop), 0);
        fstart();
        chk("f2_swap_front", 32'(front_bank), 0);
        chk("f2_swap_pending", 32'(frame_pending), 0);
        rd_issue(0, 0, 0, 8'd1, 0);
        rd_issue(15, 7, 0, 8'd38, 0);
        rd_stop();
        drain();

        // Out-of-range writes drop even with no frame pending.
        wr_px(20, 0, 8'h11);
        wr_px(0, 9, 8'h22);
        chk("drop_count_3", 32'(drop_count), 3);

        // Frame 3: last pixel coincides with frame start -> no swap.
        wr_frame(3, 1);
        chk("f3_not_pending", 32'(frame_pending), 0);
        wr_valid = 1'b1;
        wr_x = XW'(W - 1);
        wr_y = YW'(H - 1);
        wr_data = 8'h7F;
        rd_frame_start = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_frame_start = 1'b0;
        chk("coinc_no_swap", 32'(front_bank), 0);
        chk("coinc_pending", 32'(frame_pending), 1);
        fstart();
        chk("f3_swap_front", 32'(front_bank), 1);
        chk("f3_swap_pending", 32'(frame_pending), 0);
        rd_issue(7, 7, 0, 8'h77, 0);
        rd_issue(15, 7, 0, 8'h7F, 0);
        rd_issue(15, 0, 1, 8'h00, 0);
        rd_stop();
        drain();

        // Frame 4 pends; flood drops to saturate the counter.
        wr_frame(4, 0);
        chk("f4_pending", 32'(frame_pending), 1);
        chk("drop_count_pre", 32'(drop_count), 3);
        wr_valid = 1'b1;
        wr_x = '0;
        wr_y = '0;
        repeat (65540) tick();
        wr_valid = 1'b0;
        chk("drop_sat", 32'(drop_count), 32'hFFFF);
        tick();
        chk("drop_sat_hold", 32'(drop_count), 32'hFFFF);
        chk("drop_idle", 32'(wr_drop), 0);

        // Asynchronous reset with reads in flight.
        rd_issue(1, 2, 0, 8'h21, 0);
        rd_issue(2, 2, 0, 8'h22, 0);
        rd_issue(3, 2, 0, 8'h23, 0);
        rd_stop();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rd_valid", 32'(rd_valid), 0);
        chk("arst_rd_data", 32'(rd_data), 0);
        q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("arst_front", 32'(front_bank), 0);
        chk("arst_pending", 32'(frame_pending), 0);
        chk("arst_drop_count", 32'(drop_count), 0);
        drain();
        chk("rd_queue_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
